// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with optional hardwired zero register
// and optional same-cycle write-to-read forwarding.
module regfile_2r1w #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              En,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  WrData,
    input  logic [ADDR_W-1:0] RdAddrA,
    output logic [WIDTH-1:0]  RdDataA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [WIDTH-1:0]  RdDataB
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic wr_in_range;
    logic wr_zero;
    logic wq;

    logic a_in_range;
    logic a_zero;
    logic a_fwd;
    logic b_in_range;
    logic b_zero;
    logic b_fwd;

    // Qualify the write: out-of-range and zero-register writes are dropped.
    always_comb begin
        wr_in_range = ({1'b0, WrAddr} < DEPTH_C);
        wr_zero     = (ZERO_REG != 0) && (WrAddr == '0);
        wq          = Reset && En && WrEn && wr_in_range && !wr_zero;
    end

    // Storage update; reset wins over any concurrent write.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wq) begin
            mem[WrAddr] <= WrData;
        end
    end

    // Per-port read qualifiers.
    always_comb begin
        a_in_range = ({1'b0, RdAddrA} < DEPTH_C);
        a_zero     = (ZERO_REG != 0) && (RdAddrA == '0);
        a_fwd      = (BYPASS != 0) && wq && (WrAddr == RdAddrA);
        b_in_range = ({1'b0, RdAddrB} < DEPTH_C);
        b_zero     = (ZERO_REG != 0) && (RdAddrB == '0);
        b_fwd      = (BYPASS != 0) && wq && (WrAddr == RdAddrB);
    end

    // Port A read mux: range, zero, forward, then storage.
    always_comb begin
        RdDataA = '0;
        if (!a_in_range) begin
            RdDataA = '0;
        end else if (a_zero) begin
            RdDataA = '0;
        end else if (a_fwd) begin
            RdDataA = WrData;
        end else begin
            RdDataA = mem[RdAddrA];
        end
    end

    // Port B read mux: range, zero, forward, then storage.
    always_comb begin
        RdDataB = '0;
        if (!b_in_range) begin
            RdDataB = '0;
        end else if (b_zero) begin
            RdDataB = '0;
        end else if (b_fwd) begin
            RdDataB = WrData;
        end else begin
            RdDataB = mem[RdAddrB];
        end
    end

endmodule
